corr_pkt_reader: RTL and testbench

Consumer at the read end of the correlator packet FIFO. It pops 5-byte window packets, in the order winNum, countX, countY, countIsect, countSymdiff. It reassembles each packet into a parallel record, checks winNum continuity to detect dropped packets, and presents the records downstream on a valid/ready interface. It sits between the correlator's pktfifo (show-ahead, empty/pop/flush) and the host-side bridge or logging logic.

---
 rtl/corr_pkt_pkg.sv | 19 +
 rtl/corr_seq_check.sv | 56 +++++
 rtl/corr_pkt_reader.sv | 121 ++++++++++++
 tb/tb_corr_pkt_reader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/corr_pkt_pkg.sv
// Shared constants and record layout for the correlator packet reader.
package corr_pkt_pkg;

   localparam int PKT_NBYTES      = 5;
   localparam int PKT_IDX_WINNUM  = 0;
   localparam int PKT_IDX_COUNTX  = 1;
   localparam int PKT_IDX_COUNTY  = 2;
   localparam int PKT_IDX_ISECT   = 3;
   localparam int PKT_IDX_SYMDIFF = 4;

   typedef struct packed {
      logic [7:0] winNum;
      logic [7:0] countX;
      logic [7:0] countY;
      logic [7:0] countIsect;
      logic [7:0] countSymdiff;
   } pktRec_t;

endpackage

// File: rtl/corr_seq_check.sv
// Window-number continuity tracker: expected winNum, sync flag, saturating drop count
// and a one-cycle error pulse aligned with the record load.
module corr_seq_check #(
   parameter int DROPCOUNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cg,
   input  logic                   load,
   input  logic [7:0]             winNum,
   input  logic                   clrSync,
   output logic                   seqErr,
   output logic [DROPCOUNT_W-1:0] nDropped,
   output logic                   synced
);
   import corr_pkt_pkg::*;

   localparam int SUM_W = DROPCOUNT_W + 9;
   localparam logic [SUM_W-1:0] DROP_MAX = {{9{1'b0}}, {DROPCOUNT_W{1'b1}}};

   logic [7:0]             expectedQ;
   logic [7:0]             gap;
   logic [SUM_W-1:0]       sumWide;
   logic [DROPCOUNT_W-1:0] dropSat;

   // Gap is modulo 256, so a wrap from FE to 01 counts two missing windows.
   always_comb begin
      gap     = winNum - expectedQ;
      sumWide = {9'd0, nDropped} + {{(SUM_W-8){1'b0}}, gap};
      dropSat = (sumWide > DROP_MAX) ? {DROPCOUNT_W{1'b1}} : sumWide[DROPCOUNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         expectedQ <= '0;
         synced    <= 1'b0;
         nDropped  <= '0;
         seqErr    <= 1'b0;
      end else begin
         seqErr <= 1'b0;
         if (cg) begin
            if (clrSync) begin
               synced <= 1'b0;
            end else if (load) begin
               expectedQ <= winNum + 8'd1;
               synced    <= 1'b1;
               if (synced && (winNum != expectedQ)) begin
                  seqErr   <= 1'b1;
                  nDropped <= dropSat;
               end
            end
         end
      end
   end

endmodule

// File: rtl/corr_pkt_reader.sv
// Pops 5-byte window packets from the show-ahead pktfifo, rebuilds them into records
// and hands them downstream on valid/ready while tracking winNum continuity.
//  state | meaning
//  B0    | expecting winNum byte
//  B1    | expecting countX byte
//  B2    | expecting countY byte
//  B3    | expecting countIsect byte
//  B4    | expecting countSymdiff; pops only when the output register is free or draining
module corr_pkt_reader #(
   parameter int DROPCOUNT_W = 16,
   parameter int PKT_NBYTES  = 5
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_cg,
   input  logic [7:0]             i_pktfifo_data,
   input  logic                   i_pktfifo_empty,
   output logic                   o_pktfifo_pop,
   output logic                   o_pktfifo_flush,
   input  logic                   i_resync,
   output logic                   o_pkt_valid,
   input  logic                   i_pkt_ready,
   output logic [7:0]             o_winNum,
   output logic [7:0]             o_countX,
   output logic [7:0]             o_countY,
   output logic [7:0]             o_countIsect,
   output logic [7:0]             o_countSymdiff,
   output logic                   o_seqErr,
   output logic [DROPCOUNT_W-1:0] o_nDropped,
   output logic                   o_synced
);
   import corr_pkt_pkg::*;

   if (PKT_NBYTES != corr_pkt_pkg::PKT_NBYTES) begin : badNbytes
      $error("corr_pkt_reader only supports 5-byte packets");
   end

   typedef enum logic [2:0] {
      B0 = 3'(PKT_IDX_WINNUM),
      B1 = 3'(PKT_IDX_COUNTX),
      B2 = 3'(PKT_IDX_COUNTY),
      B3 = 3'(PKT_IDX_ISECT),
      B4 = 3'(PKT_IDX_SYMDIFF)
   } asmState_t;

   asmState_t  stateQ, stateD;
   logic [7:0] partQ [PKT_IDX_WINNUM:PKT_IDX_ISECT];
   pktRec_t    recQ;
   logic       validQ;
   logic       accept, popByte, loadRec, xferOut, resyncNow;

   always_comb begin
      resyncNow = i_cg && i_resync && !i_rst;
      accept    = (stateQ != B4) || !validQ || i_pkt_ready;
      popByte   = i_cg && !i_rst && !i_resync && !i_pktfifo_empty && accept;
      loadRec   = popByte && (stateQ == B4);
      xferOut   = i_cg && validQ && i_pkt_ready;
      stateD    = stateQ;
      if (resyncNow) begin
         stateD = B0;
      end else if (popByte) begin
         case (stateQ)
            B0:      stateD = B1;
            B1:      stateD = B2;
            B2:      stateD = B3;
            B3:      stateD = B4;
            default: stateD = B0;
         endcase
      end
   end

   // Show-ahead FIFO: the head byte is captured in the same cycle it is popped.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         stateQ <= B0;
         partQ  <= '{default: '0};
         recQ   <= '0;
         validQ <= 1'b0;
      end else if (i_cg) begin
         stateQ <= stateD;
         if (popByte) begin
            case (stateQ)
               B0:      partQ[PKT_IDX_WINNUM] <= i_pktfifo_data;
               B1:      partQ[PKT_IDX_COUNTX] <= i_pktfifo_data;
               B2:      partQ[PKT_IDX_COUNTY] <= i_pktfifo_data;
               B3:      partQ[PKT_IDX_ISECT]  <= i_pktfifo_data;
               default: ;
            endcase
         end
         if (loadRec) begin
            recQ   <= {partQ[PKT_IDX_WINNUM], partQ[PKT_IDX_COUNTX], partQ[PKT_IDX_COUNTY],
                       partQ[PKT_IDX_ISECT], i_pktfifo_data};
            validQ <= 1'b1;
         end else if (xferOut) begin
            validQ <= 1'b0;
         end
      end
   end

   corr_seq_check #(.DROPCOUNT_W(DROPCOUNT_W)) seqCheck (
      .clk      (i_clk),
      .rst      (i_rst),
      .cg       (i_cg),
      .load     (loadRec),
      .winNum   (partQ[PKT_IDX_WINNUM]),
      .clrSync  (resyncNow),
      .seqErr   (o_seqErr),
      .nDropped (o_nDropped),
      .synced   (o_synced)
   );

   assign o_pktfifo_pop   = popByte;
   assign o_pktfifo_flush = resyncNow;
   assign o_pkt_valid     = validQ;
   assign o_winNum        = recQ.winNum;
   assign o_countX        = recQ.countX;
   assign o_countY        = recQ.countY;
   assign o_countIsect    = recQ.countIsect;
   assign o_countSymdiff  = recQ.countSymdiff;

endmodule

// File: tb/tb_corr_pkt_reader.sv
// Bench for corr_pkt_reader: a queue-based show-ahead FIFO feeds packets and a
// packet-level model predicts records, seqErr flags and the drop count.
module tb_corr_pkt_reader;

   logic        i_clk = 1'b0;
   logic        i_rst, i_cg, i_resync, i_pkt_ready, i_pktfifo_empty;
   logic [7:0]  i_pktfifo_data;
   logic        o_pktfifo_pop, o_pktfifo_flush, o_pkt_valid, o_seqErr, o_synced;
   logic [7:0]  o_winNum, o_countX, o_countY, o_countIsect, o_countSymdiff;
   logic [15:0] o_nDropped;

   always #5 i_clk = ~i_clk;

   corr_pkt_reader #(.DROPCOUNT_W(16), .PKT_NBYTES(5)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_cg(i_cg),
      .i_pktfifo_data(i_pktfifo_data), .i_pktfifo_empty(i_pktfifo_empty),
      .o_pktfifo_pop(o_pktfifo_pop), .o_pktfifo_flush(o_pktfifo_flush),
      .i_resync(i_resync), .o_pkt_valid(o_pkt_valid), .i_pkt_ready(i_pkt_ready),
      .o_winNum(o_winNum), .o_countX(o_countX), .o_countY(o_countY),
      .o_countIsect(o_countIsect), .o_countSymdiff(o_countSymdiff),
      .o_seqErr(o_seqErr), .o_nDropped(o_nDropped), .o_synced(o_synced)
   );

   typedef struct {
      logic [39:0] rec;
      bit          err;
      int          drop;
   } expRec_t;

   logic [7:0] fifoQ[$];
   expRec_t    expQ[$];
   int         nChecks = 0, nErrs = 0, cyc = 0;
   int         lastDeliv = -100, prevDeliv = -100, delivCnt = 0;
   bit         errSeen = 0, sValid = 0, sPop = 0;
   bit         mSynced = 0;
   logic [7:0] mExp = '0;
   int         mDrop = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrs++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic driveFifo();
      i_pktfifo_empty = (fifoQ.size() == 0);
      i_pktfifo_data  = (fifoQ.size() == 0) ? 8'h00 : fifoQ[0];
   endtask

   task automatic pushRaw(input logic [7:0] b);
      fifoQ.push_back(b);
      driveFifo();
   endtask

   // Packet-level sequence model: first packet after (re)sync only sets the expectation.
   task automatic pushPkt(input logic [7:0] w, input logic [7:0] c1, input logic [7:0] c2,
                          input logic [7:0] c3, input logic [7:0] c4);
      expRec_t    e;
      logic [7:0] gap8;
      int         sum;
      e.err = 0;
      if (!mSynced) begin
         mSynced = 1;
      end else if (w != mExp) begin
         gap8  = w - mExp;
         sum   = mDrop + int'(gap8);
         mDrop = (sum > 65535) ? 65535 : sum;
         e.err = 1;
      end
      mExp   = w + 8'd1;
      e.rec  = {w, c1, c2, c3, c4};
      e.drop = mDrop;
      expQ.push_back(e);
      pushRaw(w); pushRaw(c1); pushRaw(c2); pushRaw(c3); pushRaw(c4);
   endtask

   task automatic cycle();
      bit popS, flushS;
      @(negedge i_clk);
      cyc++;
      chk("flush", o_pktfifo_flush, i_cg && i_resync && !i_rst);
      if (!i_cg || i_resync || i_rst) chk("popGated", o_pktfifo_pop, 1'b0);
      if (fifoQ.size() == 0) chk("popEmpty", o_pktfifo_pop, 1'b0);
      sValid = o_pkt_valid;
      sPop   = o_pktfifo_pop;
      if (!i_rst) begin
         errSeen |= o_seqErr;
         if (o_pkt_valid) begin
            if (expQ.size() == 0) begin
               chk("spuriousValid", o_pkt_valid, 1'b0);
            end else begin
               chk("rec", {o_winNum, o_countX, o_countY, o_countIsect, o_countSymdiff}, expQ[0].rec);
               if (i_pkt_ready && i_cg) begin
                  chk("seqErr", errSeen, expQ[0].err);
                  chk("nDropped", o_nDropped, expQ[0].drop);
                  errSeen   = 0;
                  prevDeliv = lastDeliv;
                  lastDeliv = cyc;
                  delivCnt++;
                  void'(expQ.pop_front());
               end
            end
         end
      end
      popS   = o_pktfifo_pop;
      flushS = o_pktfifo_flush;
      @(posedge i_clk);
      #1;
      if (popS && fifoQ.size() > 0) void'(fifoQ.pop_front());
      if (flushS) fifoQ.delete();
      driveFifo();
   endtask

   task automatic drain(input int budget);
      int k = 0;
      while ((fifoQ.size() > 0 || expQ.size() > 0) && k < budget) begin
         cycle();
         k++;
      end
      chk("drainLeft", fifoQ.size() + expQ.size(), 0);
      cycle();
   endtask

   task automatic doResync();
      i_resync = 1;
      cycle();
      i_resync = 0;
      mSynced  = 0;
   endtask

   initial begin
      int n;
      logic [7:0] w;
      i_rst = 1; i_cg = 1; i_resync = 0; i_pkt_ready = 1;
      driveFifo();
      repeat (3) cycle();
      i_rst = 0;
      chk("rstValid", o_pkt_valid, 1'b0);
      chk("rstRec", {o_winNum, o_countX, o_countY, o_countIsect, o_countSymdiff}, 40'h0);
      chk("rstDrop", o_nDropped, 16'd0);
      chk("rstSynced", o_synced, 1'b0);
      chk("rstSeqErr", o_seqErr, 1'b0);
      chk("rstPop", o_pktfifo_pop, 1'b0);

      // Three clean packets, first record visible on the 6th sampled cycle.
      pushPkt(8'h00, 8'h11, 8'h22, 8'h33, 8'h44);
      pushPkt(8'h01, 8'h11, 8'h22, 8'h33, 8'h44);
      pushPkt(8'h02, 8'h11, 8'h22, 8'h33, 8'h44);
      n = 0;
      do begin cycle(); n++; end while (!sValid && n < 20);
      chk("latency", n, 6);
      drain(100);
      chk("cleanCount", delivCnt, 3);
      chk("cleanSynced", o_synced, 1'b1);
      chk("cleanDrop", o_nDropped, 16'd0);

      // Resync with a record pending and two bytes of a partial packet consumed.
      i_pkt_ready = 0;
      pushPkt(8'h03, 8'hA1, 8'hA2, 8'hA3, 8'hA4);
      pushRaw(8'h77); pushRaw(8'h11);
      n = 0;
      while (fifoQ.size() > 0 && n < 30) begin cycle(); n++; end
      chk("partialPopped", fifoQ.size(), 0);
      pushRaw(8'h22);
      doResync();
      cycle();
      chk("resyncSynced", o_synced, 1'b0);
      chk("resyncFlushed", fifoQ.size(), 0);
      i_pkt_ready = 1;
      pushPkt(8'h40, 8'hB1, 8'hB2, 8'hB3, 8'hB4);
      drain(100);
      chk("resyncResynced", o_synced, 1'b1);
      chk("resyncDrop", o_nDropped, 16'd0);

      // Clock-gate hold in the middle of a packet.
      pushPkt(8'h41, 8'hC1, 8'hC2, 8'hC3, 8'hC4);
      cycle(); cycle();
      i_cg = 0;
      repeat (5) cycle();
      chk("cgHold", fifoQ.size(), 3);
      i_cg = 1;
      drain(100);

      // Gap of three windows, then wrap-around cases.
      doResync();
      pushPkt(8'h05, 8'h01, 8'h02, 8'h03, 8'h04);
      pushPkt(8'h09, 8'h05, 8'h06, 8'h07, 8'h08);
      drain(100);
      chk("gapDrop", o_nDropped, 16'd3);
      doResync();
      pushPkt(8'hFE, 8'h10, 8'h20, 8'h30, 8'h40);
      pushPkt(8'h01, 8'h50, 8'h60, 8'h70, 8'h80);
      drain(100);
      chk("wrapGapDrop", o_nDropped, 16'd5);
      doResync();
      pushPkt(8'hFF, 8'h13, 8'h24, 8'h35, 8'h46);
      pushPkt(8'h00, 8'h57, 8'h68, 8'h79, 8'h8A);
      drain(100);
      chk("wrapCleanDrop", o_nDropped, 16'd5);

      // Downstream stall with two packets queued.
      i_pkt_ready = 0;
      pushPkt(8'h01, 8'hD1, 8'hD2, 8'hD3, 8'hD4);
      pushPkt(8'h02, 8'hE1, 8'hE2, 8'hE3, 8'hE4);
      repeat (20) cycle();
      chk("stallValid", sValid, 1'b1);
      chk("stallPop", sPop, 1'b0);
      chk("stallFifo", fifoQ.size(), 1);
      i_pkt_ready = 1;
      drain(100);
      chk("backToBack", lastDeliv - prevDeliv, 1);

      // Randomized traffic with occasional winNum jumps, ready and clock-gate toggling.
      for (int i = 0; i < 200; i++) begin
         w = ($urandom_range(0, 3) == 0) ? 8'($urandom) : mExp;
         pushPkt(w, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         for (int j = 0; j < $urandom_range(0, 6); j++) begin
            i_pkt_ready = ($urandom_range(0, 9) < 7);
            i_cg        = ($urandom_range(0, 9) < 9);
            cycle();
         end
      end
      i_pkt_ready = 1;
      i_cg        = 1;
      drain(3000);
      chk("randDrop", o_nDropped, mDrop);
      chk("randSynced", o_synced, 1'b1);

      $display("Result: errors=%0d of %0d checks", nErrs, nChecks);
      $finish;
   end

endmodule
